mux_sel_pipe: RTL and testbench
===============================

# mux_sel_pipe

Parametrised, registered successor to the datapath source selector. Selects one of `CH` source channels per transaction, forces the designated zero channel to 0, and widens the designated narrow channel. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides. The block sits between the execute-stage sources (ALU, constant zero, shift amount/immediate, memory) and the register-file write port, so write-back can stall without losing results.

## Interface
Parameters:
- `N`, 8: data width of every channel and of the output.
- `CH`, 4: number of source channels (2..16).
- `ZERO_CH`, 1: index of the channel whose output is forced to all-zeros; its input is ignored.
- `NARROW_CH`, 2: index of the narrow channel.
- `NARROW_W`, 5: significant width of the narrow channel (1..N).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  CH×N  packed source array; channel c is `in_data[c]`.
- `in_sel`  in  SELW = max(1, clog2(CH))  channel select for this transaction.
- `in_valid`  in  1  a transaction is presented.
- `in_ready`  out  1  the block can accept a transaction this cycle.
- `out_data`  out  N  selected and extended result.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  the consumer accepts `out_data` this cycle.
- `sel_err`  out  1  sticky flag: a transaction used `in_sel` ≥ CH.

## Operation
- Accept occurs when `in_valid && in_ready` at a rising edge. Data is computed from `in_data`/`in_sel` in that cycle and pushed into the buffer.
- Selection rules:
  - Channel `ZERO_CH` produces 0.
  - Channel `NARROW_CH` produces `in_data[NARROW_CH][NARROW_W-1:0]`, extended to N bits.
  - Every other channel c produces `in_data[c]`.
- Out-of-range select (`in_sel` ≥ CH): the transaction is still accepted, its result is 0, and `sel_err` is set. `sel_err` clears only on reset.
- Buffer is a 2-entry FIFO with occupancy `count` ∈ {0,1,2}:
  - `in_ready = (count != 2)`, driven only from registered state; there is no combinational path from `out_ready` to `in_ready`.
  - `out_valid = (count != 0)`; `out_data` is the oldest entry.
  - Pop occurs when `out_valid && out_ready`.
  - Push and pop in the same edge: `count` is unchanged and order is preserved.
  - Full (`count == 2`): no push is possible, even if a pop occurs in the same cycle; `in_ready` rises the cycle after the pop.
  - Empty: `out_data` holds its last value, and its content is don't-care while `out_valid` is 0.
- Output order equals acceptance order; no transaction is dropped or duplicated.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n` low): `count` = 0, `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `sel_err` = 0, and both buffer entries = 0.
- Reset mid-operation discards all buffered results. The first accept is allowed at the first rising edge after `rst_n` deasserts.
- Latency is one cycle: a transaction accepted at edge k is visible with `out_valid` = 1 after edge k.
- With `out_ready` held high, throughput is one transaction per cycle.
- `sel_err` rises after the edge that accepts the offending transaction.

## Configuration
- `MUX_SIGN_EXT_EN` defined: the narrow channel is sign-extended, i.e. bit `NARROW_W-1` is replicated into bits N-1..NARROW_W.
- `MUX_SIGN_EXT_EN` undefined (default): the narrow channel is zero-extended.
- When `NARROW_W == N` the macro has no effect.

## Structure
- Package `mux_pkg` holds:
  - the `SELW` computation function;
  - the `cnt_t` typedef (2-bit buffer occupancy);
  - localparam `BUF_DEPTH = 2`.
- Sub-module `mux_skid_buf`: the parametrised-width 2-entry FIFO with valid/ready ports, instantiated once.
- Selection/extension logic stays in the top level.
- Elaboration-time checks: `ZERO_CH` ≠ `NARROW_CH`, and both indices are < CH.

## Test plan
- Reset, then `in_sel=3`, `in_data[3]=8'hA5`, single accept with `out_ready=1` -> after 1 cycle `out_valid=1` and `out_data=8'hA5`; then `out_valid=0`.
- `in_sel=1` with `in_data[1]=8'hFF` -> `out_data=8'h00`. `in_sel=2` with `in_data[2]=8'hF3`:
  - without macro -> `out_data=8'h13`;
  - with `MUX_SIGN_EXT_EN` -> `out_data=8'hF3`.
- `out_ready=0`, three back-to-back valid transactions (values 1, 2, 3) -> first two accepted and `in_ready=0`; raise `out_ready` -> outputs 1, 2, 3 in order, with no loss.
- Full buffer, then `out_ready=1` and `in_valid=1` in the same cycle -> pop occurs, no push; `in_ready=1` the next cycle.
- `CH=3`, `in_sel=3` -> `out_data=0` and `sel_err=1`, which stays 1 through later valid transactions until `rst_n` is asserted.
- `rst_n` asserted while `count=2` -> `out_valid=0` and `in_ready=1` immediately; no stale data appears after deassertion.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and sizing helpers for the mux_sel_pipe selector and its output buffer.
package mux_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    // Two bits cover occupancy 0..BUF_DEPTH
    typedef logic [1:0] cnt_t;

    // Select width: at least one bit even for a two-channel mux
    function automatic int unsigned sel_w(input int unsigned ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/mux_sel_pipe_if.sv
// Source-select request and buffered result handshake bundle for mux_sel_pipe.
interface mux_sel_pipe_if
    import mux_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned CH   = 4,
    parameter int unsigned SELW = sel_w(CH)
);

    logic [CH-1:0][N-1:0] in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sel_err;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );

endinterface

// File: rtl/mux_skid_buf.sv
// Two-entry in-order FIFO with valid/ready on both sides; ready/valid come straight from flops.
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data
);

    localparam cnt_t FULL = cnt_t'(BUF_DEPTH);

    cnt_t         r_count;
    logic [W-1:0] r_ent0;
    logic [W-1:0] r_ent1;
    logic         r_in_ready;
    logic         r_out_valid;

    logic w_push;
    logic w_pop;
    cnt_t w_count_nxt;

    assign w_push = i_in_valid && r_in_ready;
    assign w_pop  = r_out_valid && i_out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = cnt_t'(r_count + cnt_t'(1));
        end else if (w_pop && !w_push) begin
            w_count_nxt = cnt_t'(r_count - cnt_t'(1));
        end
    end

    // r_ent0 is always the oldest entry, so it drives the output directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_ent0      <= '0;
            r_ent1      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != FULL);
            r_out_valid <= (w_count_nxt != cnt_t'(0));
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == cnt_t'(0)) begin
                        r_ent0 <= i_in_data;
                    end else begin
                        r_ent1 <= i_in_data;
                    end
                end
                2'b01: begin
                    if (r_count == FULL) begin
                        r_ent0 <= r_ent1;
                    end
                end
                2'b11: begin
                    r_ent0 <= i_in_data;
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_ent0;

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered datapath source selector: zero channel, narrow channel extension, 2-deep result buffer.
// Define MUX_SIGN_EXT_EN to sign-extend the narrow channel instead of zero-extending it.
module mux_sel_pipe
    import mux_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned CH        = 4,
    parameter int unsigned ZERO_CH   = 1,
    parameter int unsigned NARROW_CH = 2,
    parameter int unsigned NARROW_W  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_sel_pipe_if.slave bus
);

    localparam int unsigned SELW = sel_w(CH);

    if (ZERO_CH == NARROW_CH) begin : g_chk_distinct
        $error("mux_sel_pipe: ZERO_CH and NARROW_CH must differ");
    end
    if (ZERO_CH >= CH || NARROW_CH >= CH) begin : g_chk_range
        $error("mux_sel_pipe: ZERO_CH and NARROW_CH must be below CH");
    end
    if (NARROW_W < 1 || NARROW_W > N) begin : g_chk_narrow
        $error("mux_sel_pipe: NARROW_W must lie in 1..N");
    end

    logic [NARROW_W-1:0] w_narrow;
    logic [N-1:0]        w_narrow_ext;
    logic [N-1:0]        w_sel_data;
    logic                w_sel_oob;
    logic                w_accept;
    logic                r_sel_err;

    assign w_narrow = bus.in_data[NARROW_CH][NARROW_W-1:0];

`ifdef MUX_SIGN_EXT_EN
    assign w_narrow_ext = N'($signed(w_narrow));
`else
    assign w_narrow_ext = N'(w_narrow);
`endif

    // Out-of-range selects only exist when CH is not a power of two
    if (CH < (2 ** SELW)) begin : g_oob
        assign w_sel_oob = (bus.in_sel >= SELW'(CH));
    end else begin : g_no_oob
        assign w_sel_oob = 1'b0;
    end

    // Unmatched (out-of-range) selects fall through to zero
    always_comb begin
        w_sel_data = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (bus.in_sel == SELW'(c)) begin
                if (c == ZERO_CH) begin
                    w_sel_data = '0;
                end else if (c == NARROW_CH) begin
                    w_sel_data = w_narrow_ext;
                end else begin
                    w_sel_data = bus.in_data[c];
                end
            end
        end
    end

    assign w_accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_oob) begin
            r_sel_err <= 1'b1;
        end
    end

    assign bus.sel_err = r_sel_err;

    mux_skid_buf #(
        .W (N)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (bus.in_valid),
        .o_in_ready  (bus.in_ready),
        .i_in_data   (w_sel_data),
        .o_out_valid (bus.out_valid),
        .i_out_ready (bus.out_ready),
        .o_out_data  (bus.out_data)
    );

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: directed steps plus random traffic against a queue-based reference.
module tb_mux_sel_pipe;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    logic [7:0] q[$];

    mux_sel_pipe_if #(.N(8), .CH(4)) ifa ();
    mux_sel_pipe_if #(.N(8), .CH(3)) ifb ();

    mux_sel_pipe #(.N(8), .CH(4), .ZERO_CH(1), .NARROW_CH(2), .NARROW_W(5)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    mux_sel_pipe #(.N(8), .CH(3), .ZERO_CH(1), .NARROW_CH(2), .NARROW_W(5)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected result for a 4-channel, ZERO_CH=1, NARROW_CH=2, NARROW_W=5 selector
    function automatic logic [7:0] ref_val(input logic [1:0] sel, input logic [3:0][7:0] d);
        logic [7:0] low5;
        low5 = d[2] % 8'd32;
        case (sel)
            2'd1: return 8'd0;
            2'd2: begin
`ifdef MUX_SIGN_EXT_EN
                return (low5 >= 8'd16) ? (low5 + 8'd224) : low5;
`else
                return low5;
`endif
            end
            default: return d[sel];
        endcase
    endfunction

    // One clock: check state against the reference, then advance it by the rules of accept/pop
    task automatic tick();
        bit         acc;
        bit         pop;
        logic [7:0] e;
        @(negedge clk);
        chk("out_valid", 8'(ifa.out_valid), 8'(q.size() != 0));
        chk("in_ready", 8'(ifa.in_ready), 8'(q.size() != 2));
        if (q.size() != 0) chk("out_data", ifa.out_data, q[0]);
        acc = ifa.in_valid && (q.size() < 2);
        pop = ifa.out_ready && (q.size() > 0);
        e   = ref_val(ifa.in_sel, ifa.in_data);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifa.in_data = '0; ifa.in_sel = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_data = '0; ifb.in_sel = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 8'(ifa.out_valid), 8'd0);
        chk("rst_in_ready", 8'(ifa.in_ready), 8'd1);
        chk("rst_out_data", ifa.out_data, 8'h00);
        chk("rst_sel_err", 8'(ifa.sel_err), 8'd0);
        chk("rst_b_sel_err", 8'(ifb.sel_err), 8'd0);
        rst_n = 1'b1;

        // Single transaction latency
        ifa.in_sel = 2'd3; ifa.in_data[3] = 8'hA5; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        chk("lat_valid", 8'(ifa.out_valid), 8'd1);
        chk("lat_data", ifa.out_data, 8'hA5);
        tick();
        chk("lat_drain", 8'(ifa.out_valid), 8'd0);

        // Zero channel and narrow channel
        ifa.in_sel = 2'd1; ifa.in_data[1] = 8'hFF; ifa.in_valid = 1'b1;
        tick();
        chk("zero_ch", ifa.out_data, 8'h00);
        ifa.in_sel = 2'd2; ifa.in_data[2] = 8'hF3;
        tick();
`ifdef MUX_SIGN_EXT_EN
        chk("narrow_ch", ifa.out_data, 8'hF3);
`else
        chk("narrow_ch", ifa.out_data, 8'h13);
`endif
        ifa.in_valid = 1'b0;
        tick();

        // Backpressure: fill, hold a third, then pop from full with in_valid high
        ifa.out_ready = 1'b0; ifa.in_sel = 2'd0; ifa.in_valid = 1'b1;
        ifa.in_data[0] = 8'd1; tick();
        ifa.in_data[0] = 8'd2; tick();
        chk("full_in_ready", 8'(ifa.in_ready), 8'd0);
        chk("full_head", ifa.out_data, 8'd1);
        ifa.in_data[0] = 8'd3; tick();
        chk("full_hold", 8'(ifa.in_ready), 8'd0);
        ifa.out_ready = 1'b1;
        tick();
        chk("pop_full_ready", 8'(ifa.in_ready), 8'd1);
        chk("pop_full_data", ifa.out_data, 8'd2);
        tick();
        chk("third_data", ifa.out_data, 8'd3);
        ifa.in_valid = 1'b0;
        tick();
        tick();

        // Out-of-range select on the 3-channel instance
        ifb.in_sel = 2'd3; ifb.in_data = {8'h77, 8'h66, 8'h55}; ifb.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("oob_data", ifb.out_data, 8'h00);
        chk("oob_err", 8'(ifb.sel_err), 8'd1);
        ifb.in_sel = 2'd0; ifb.in_data[0] = 8'h5C;
        @(posedge clk); #1;
        chk("after_oob_data", ifb.out_data, 8'h5C);
        chk("err_sticky", 8'(ifb.sel_err), 8'd1);
        ifb.in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("err_sticky2", 8'(ifb.sel_err), 8'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ifa.in_valid  = 1'($urandom_range(0, 1));
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            ifa.in_sel    = 2'($urandom_range(0, 3));
            for (int c = 0; c < 4; c++) ifa.in_data[c] = 8'($urandom);
            tick();
        end

        // Reset while full discards everything
        ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_sel = 2'd0;
        ifa.in_data[0] = 8'h3C; tick();
        ifa.in_data[0] = 8'h4D; tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 8'(ifa.out_valid), 8'd0);
        chk("mid_rst_ready", 8'(ifa.in_ready), 8'd1);
        chk("mid_rst_err", 8'(ifb.sel_err), 8'd0);
        q.delete();
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("no_stale", 8'(ifa.out_valid), 8'd0);
        ifa.in_valid = 1'b1; ifa.in_sel = 2'd3; ifa.in_data[3] = 8'h9E;
        tick();
        ifa.in_valid = 1'b0;
        chk("post_rst_data", ifa.out_data, 8'h9E);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
